// File: rtl/semaforo_pkg.sv
// Shared definitions for the multi-approach traffic-light controller.
//   phase_e    : phase encoding as seen on the phase output
//   BIT_*/LT_* : bit positions and 3-bit patterns of one {R,Y,G} lamp group
//   TIMER_W    : width of the phase/blink timer
//   tload()    : timer load value for a phase lasting t ticks
package semaforo_pkg;

  localparam int unsigned TIMER_W = 8;

  localparam int unsigned BIT_G = 0;
  localparam int unsigned BIT_Y = 1;
  localparam int unsigned BIT_R = 2;

  localparam logic [2:0] LT_OFF = 3'b000;
  localparam logic [2:0] LT_G   = 3'b001 << BIT_G;
  localparam logic [2:0] LT_Y   = 3'b001 << BIT_Y;
  localparam logic [2:0] LT_R   = 3'b001 << BIT_R;

  typedef enum logic [2:0] {
    PH_ALLRED = 3'd0,
    PH_GREEN  = 3'd1,
    PH_YELLOW = 3'd2,
    PH_PED    = 3'd3,
    PH_NIGHT  = 3'd4
  } phase_e;

  // The timer counts down to zero and the phase exits on the tick that
  // finds it at zero, so a phase of t ticks loads t-1.
  function automatic logic [TIMER_W-1:0] tload(input int unsigned t);
    return TIMER_W'(t - 1);
  endfunction

endpackage

// File: rtl/semaforo_tick.sv
// Timing-tick prescaler.
//   clk  : clock
//   rst  : synchronous active-high reset, clears the count
//   ena  : count enable; low holds the count and suppresses the tick
//   tick : one-cycle pulse on the cycle the count wraps from DIV-1 to 0
module semaforo_tick #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  // Combinational so that DIV=1 yields a tick on every enabled cycle.
  assign tick = ena && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (ena) begin
      cnt_d = (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/semaforo_multi.sv
// Multi-approach traffic-light controller with vehicle-actuated skipping,
// latched pedestrian requests and a night flashing-yellow mode.
//   clk, rst     : clock, synchronous active-high reset
//   ena          : run enable; low freezes timing, phase and outputs
//   veh_present  : per-approach vehicle sensor (level)
//   ped_req      : per-approach pedestrian button (pulse is enough)
//   night_mode   : request flashing-yellow operation (level)
//   light        : per approach i, bits [3i+2:3i] = {R,Y,G}, registered
//   walk         : per-approach walk signal, registered, only in PED
//   cur_way      : approach owning the current or last green
//   phase        : 0 ALLRED, 1 GREEN, 2 YELLOW, 3 PED, 4 NIGHT
module semaforo_multi
  import semaforo_pkg::*;
#(
  parameter int unsigned N_WAYS   = 4,
  parameter int unsigned DIV      = 1000,
  parameter int unsigned GREEN_T  = 20,
  parameter int unsigned YELLOW_T = 4,
  parameter int unsigned ALLRED_T = 2,
  parameter int unsigned PED_T    = 10,
  parameter int unsigned BLINK_T  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [N_WAYS-1:0]           veh_present,
  input  logic [N_WAYS-1:0]           ped_req,
  input  logic                        night_mode,
  output logic [3*N_WAYS-1:0]         light,
  output logic [N_WAYS-1:0]           walk,
  output logic [$clog2(N_WAYS)-1:0]   cur_way,
  output logic [2:0]                  phase
);

  localparam int unsigned CW = $clog2(N_WAYS);
  localparam logic [TIMER_W-1:0] T_ONE = TIMER_W'(1);

  // First approach after cur with a vehicle, cur itself checked last;
  // with no vehicles anywhere the green simply rotates.
  function automatic logic [CW-1:0] next_way(input logic [CW-1:0]     cur,
                                             input logic [N_WAYS-1:0] veh);
    logic [CW-1:0] res;
    logic          found;
    int            idx;
    res   = CW'((int'(cur) + 1) % int'(N_WAYS));
    found = 1'b0;
    for (int k = 1; k <= int'(N_WAYS); k++) begin
      idx = (int'(cur) + k) % int'(N_WAYS);
      if (!found && veh[CW'(idx)]) begin
        found = 1'b1;
        res   = CW'(idx);
      end
    end
    return res;
  endfunction

  function automatic logic [3*N_WAYS-1:0] light_of(input phase_e        ph,
                                                   input logic [CW-1:0] way,
                                                   input logic          blink);
    logic [3*N_WAYS-1:0] l;
    logic [2:0]          c;
    l = '0;
    for (int i = 0; i < int'(N_WAYS); i++) begin
      case (ph)
        PH_NIGHT:  c = blink ? LT_Y : LT_OFF;
        PH_GREEN:  c = (CW'(i) == way) ? LT_G : LT_R;
        PH_YELLOW: c = (CW'(i) == way) ? LT_Y : LT_R;
        default:   c = LT_R;
      endcase
      l[3*i +: 3] = c;
    end
    return l;
  endfunction

  phase_e              phase_q, phase_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [CW-1:0]       cur_q, cur_d, nxt;
  logic                blink_q, blink_d;
  logic [N_WAYS-1:0]   latch_q, latch_d;
  logic [N_WAYS-1:0]   mask_q, mask_d;
  logic [N_WAYS-1:0]   clr;
  logic [3*N_WAYS-1:0] light_q, light_d;
  logic [N_WAYS-1:0]   walk_q, walk_d;
  logic                tick;

  semaforo_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .tick (tick)
  );

  always_comb begin
    phase_d = phase_q;
    timer_d = timer_q;
    cur_d   = cur_q;
    blink_d = blink_q;
    mask_d  = mask_q;
    clr     = '0;
    nxt     = next_way(cur_q, veh_present);

    if (phase_q == PH_NIGHT) begin
      // Leaving night mode is immediate, not tick-aligned.
      if (ena && !night_mode) begin
        phase_d = PH_ALLRED;
        timer_d = tload(ALLRED_T);
      end else if (tick) begin
        if (timer_q == '0) begin
          blink_d = ~blink_q;
          timer_d = tload(BLINK_T);
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
    end else if (tick) begin
      if (timer_q != '0) begin
        timer_d = timer_q - T_ONE;
      end else begin
        case (phase_q)
          PH_GREEN: begin
            phase_d = PH_YELLOW;
            timer_d = tload(YELLOW_T);
          end
          PH_YELLOW: begin
            phase_d = PH_ALLRED;
            timer_d = tload(ALLRED_T);
          end
          PH_ALLRED: begin
            if (night_mode) begin
              phase_d = PH_NIGHT;
              blink_d = 1'b1;
              timer_d = tload(BLINK_T);
            end else if (|latch_q) begin
              phase_d = PH_PED;
              mask_d  = latch_q;
              timer_d = tload(PED_T);
            end else begin
              phase_d = PH_GREEN;
              cur_d   = nxt;
              timer_d = tload(GREEN_T);
            end
          end
          PH_PED: begin
            clr     = mask_q;
            phase_d = PH_GREEN;
            cur_d   = nxt;
            timer_d = tload(GREEN_T);
          end
          default: begin
            phase_d = PH_ALLRED;
            timer_d = tload(ALLRED_T);
          end
        endcase
      end
    end

    // A new press in the same cycle as the clear survives it.
    latch_d = (latch_q & ~clr) | ped_req;
    light_d = light_of(phase_d, cur_d, blink_d);
    walk_d  = (phase_d == PH_PED) ? mask_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_ALLRED;
      timer_q <= tload(ALLRED_T);
      cur_q   <= CW'(N_WAYS - 1);
      blink_q <= 1'b1;
      latch_q <= '0;
      mask_q  <= '0;
      light_q <= {N_WAYS{LT_R}};
      walk_q  <= '0;
    end else begin
      phase_q <= phase_d;
      timer_q <= timer_d;
      cur_q   <= cur_d;
      blink_q <= blink_d;
      latch_q <= latch_d;
      mask_q  <= mask_d;
      light_q <= light_d;
      walk_q  <= walk_d;
    end
  end

  assign light   = light_q;
  assign walk    = walk_q;
  assign cur_way = cur_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_semaforo_multi.sv
// Scoreboard bench for semaforo_multi with DIV=1 and short phase times.
module tb_semaforo_multi;

  localparam logic [2:0] P_AR  = 3'd0;
  localparam logic [2:0] P_G   = 3'd1;
  localparam logic [2:0] P_Y   = 3'd2;
  localparam logic [2:0] P_PED = 3'd3;
  localparam logic [2:0] P_N   = 3'd4;

  localparam logic [2:0] C_R = 3'b100;
  localparam logic [2:0] C_Y = 3'b010;
  localparam logic [2:0] C_G = 3'b001;

  localparam logic [11:0] ALLR = 12'h924;
  localparam logic [11:0] ALLY = 12'h492;
  localparam logic [11:0] OFF  = 12'h000;

  typedef struct packed {
    logic [2:0]  ph;
    logic [11:0] lt;
    logic [3:0]  wk;
    logic [1:0]  cw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [3:0]  veh_present = 4'b0;
  logic [3:0]  ped_req = 4'b0;
  logic        night_mode = 1'b0;
  logic [11:0] light;
  logic [3:0]  walk;
  logic [1:0]  cur_way;
  logic [2:0]  phase;

  int errors = 0;
  int checks = 0;

  exp_t  exp_q[$];
  string name_q[$];

  semaforo_multi #(
    .N_WAYS(4), .DIV(1), .GREEN_T(5), .YELLOW_T(2),
    .ALLRED_T(1), .PED_T(3), .BLINK_T(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .veh_present (veh_present),
    .ped_req     (ped_req),
    .night_mode  (night_mode),
    .light       (light),
    .walk        (walk),
    .cur_way     (cur_way),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  // All approaches red except way w, which shows colour c.
  function automatic logic [11:0] one(input int w, input logic [2:0] c);
    logic [11:0] r;
    r = ALLR;
    r[3*w +: 3] = c;
    return r;
  endfunction

  // For n clock edges, queue the state expected right after each edge.
  task automatic expect_n(input string nm, input int n, input logic [2:0] ph,
                          input logic [11:0] lt, input logic [3:0] wk,
                          input logic [1:0] cw);
    exp_t e;
    e.ph = ph;
    e.lt = lt;
    e.wk = wk;
    e.cw = cw;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expect_n("reset", 1, P_AR, ALLR, 4'b0, 2'd3);
    rst = 1'b0;
  endtask

  // Reset, then a way-0 green with a one-cycle press of p on its second
  // cycle, running through to the all-red that precedes the next phase.
  task automatic green0_with_ped(input string nm, input logic [3:0] p);
    do_reset();
    expect_n({nm, "_g0"}, 1, P_G, one(0, C_G), 4'b0, 2'd0);
    ped_req = p;
    expect_n({nm, "_g0"}, 1, P_G, one(0, C_G), 4'b0, 2'd0);
    ped_req = 4'b0;
    expect_n({nm, "_g0"}, 3, P_G, one(0, C_G), 4'b0, 2'd0);
    expect_n({nm, "_y0"}, 2, P_Y, one(0, C_Y), 4'b0, 2'd0);
    expect_n({nm, "_ar"}, 1, P_AR, ALLR, 4'b0, 2'd0);
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (phase !== e.ph || light !== e.lt || walk !== e.wk || cur_way !== e.cw) begin
          errors++;
          $display("FAIL %s: got phase=%0d light=%h walk=%b cur_way=%0d, expected phase=%0d light=%h walk=%b cur_way=%0d",
                   nm, phase, light, walk, cur_way, e.ph, e.lt, e.wk, e.cw);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got no end of stimulus, expected completion");
    $fatal(1);
  end

  initial begin
    // Plain rotation with no requests.
    do_reset();
    expect_n("s1_green0",  5, P_G,  one(0, C_G), 4'b0, 2'd0);
    expect_n("s1_yellow0", 2, P_Y,  one(0, C_Y), 4'b0, 2'd0);
    expect_n("s1_allred",  1, P_AR, ALLR,        4'b0, 2'd0);
    expect_n("s1_green1",  1, P_G,  one(1, C_G), 4'b0, 2'd1);

    // Vehicle actuation: skip, self-last, wrap-around.
    do_reset();
    expect_n("s2_g0", 2, P_G, one(0, C_G), 4'b0, 2'd0);
    veh_present = 4'b0100;
    expect_n("s2_g0", 3, P_G, one(0, C_G), 4'b0, 2'd0);
    expect_n("s2_y0", 2, P_Y, one(0, C_Y), 4'b0, 2'd0);
    expect_n("s2_ar", 1, P_AR, ALLR, 4'b0, 2'd0);
    expect_n("s2_skip_to2", 5, P_G, one(2, C_G), 4'b0, 2'd2);
    expect_n("s2_y2", 2, P_Y, one(2, C_Y), 4'b0, 2'd2);
    expect_n("s2_ar2", 1, P_AR, ALLR, 4'b0, 2'd2);
    expect_n("s2_self_last", 1, P_G, one(2, C_G), 4'b0, 2'd2);
    veh_present = 4'b0001;
    expect_n("s2_g2", 4, P_G, one(2, C_G), 4'b0, 2'd2);
    expect_n("s2_y2b", 2, P_Y, one(2, C_Y), 4'b0, 2'd2);
    expect_n("s2_ar2b", 1, P_AR, ALLR, 4'b0, 2'd2);
    expect_n("s2_wrap_to0", 1, P_G, one(0, C_G), 4'b0, 2'd0);
    veh_present = 4'b0;

    // Pedestrian phase, then latch cleared.
    green0_with_ped("s3", 4'b0010);
    expect_n("s3_ped", 3, P_PED, ALLR, 4'b0010, 2'd0);
    expect_n("s3_green1", 5, P_G, one(1, C_G), 4'b0, 2'd1);
    expect_n("s3_y1", 2, P_Y, one(1, C_Y), 4'b0, 2'd1);
    expect_n("s3_ar1", 1, P_AR, ALLR, 4'b0, 2'd1);
    expect_n("s3_latch_cleared", 1, P_G, one(2, C_G), 4'b0, 2'd2);

    // New press on the clearing edge survives.
    green0_with_ped("s4", 4'b0010);
    expect_n("s4_ped", 3, P_PED, ALLR, 4'b0010, 2'd0);
    ped_req = 4'b0010;
    expect_n("s4_green1", 1, P_G, one(1, C_G), 4'b0, 2'd1);
    ped_req = 4'b0;
    expect_n("s4_green1", 4, P_G, one(1, C_G), 4'b0, 2'd1);
    expect_n("s4_y1", 2, P_Y, one(1, C_Y), 4'b0, 2'd1);
    expect_n("s4_ar1", 1, P_AR, ALLR, 4'b0, 2'd1);
    expect_n("s4_set_wins_ped", 3, P_PED, ALLR, 4'b0010, 2'd1);
    expect_n("s4_green2", 1, P_G, one(2, C_G), 4'b0, 2'd2);

    // Night mode: requested mid-green, entered from all-red only.
    do_reset();
    expect_n("s5_g0", 2, P_G, one(0, C_G), 4'b0, 2'd0);
    night_mode = 1'b1;
    expect_n("s5_g0_not_cut", 3, P_G, one(0, C_G), 4'b0, 2'd0);
    expect_n("s5_y0", 2, P_Y, one(0, C_Y), 4'b0, 2'd0);
    expect_n("s5_ar", 1, P_AR, ALLR, 4'b0, 2'd0);
    expect_n("s5_night_on", 2, P_N, ALLY, 4'b0, 2'd0);
    expect_n("s5_night_off", 2, P_N, OFF, 4'b0, 2'd0);
    expect_n("s5_night_on2", 2, P_N, ALLY, 4'b0, 2'd0);
    night_mode = 1'b0;
    expect_n("s5_exit_allred", 1, P_AR, ALLR, 4'b0, 2'd0);
    expect_n("s5_green1", 1, P_G, one(1, C_G), 4'b0, 2'd1);

    // Enable low freezes at green timer=2; latch still captures.
    do_reset();
    expect_n("s6_g0", 3, P_G, one(0, C_G), 4'b0, 2'd0);
    ena = 1'b0;
    expect_n("s6_frozen", 3, P_G, one(0, C_G), 4'b0, 2'd0);
    ped_req = 4'b0001;
    expect_n("s6_frozen", 1, P_G, one(0, C_G), 4'b0, 2'd0);
    ped_req = 4'b0;
    expect_n("s6_frozen", 6, P_G, one(0, C_G), 4'b0, 2'd0);
    ena = 1'b1;
    expect_n("s6_resume_g0", 2, P_G, one(0, C_G), 4'b0, 2'd0);
    expect_n("s6_y0", 2, P_Y, one(0, C_Y), 4'b0, 2'd0);
    expect_n("s6_ar", 1, P_AR, ALLR, 4'b0, 2'd0);
    expect_n("s6_ped_while_frozen", 3, P_PED, ALLR, 4'b0001, 2'd0);
    expect_n("s6_green1", 1, P_G, one(1, C_G), 4'b0, 2'd1);

    // Reset mid-yellow with a latched press and enable low.
    do_reset();
    expect_n("s7_g0", 1, P_G, one(0, C_G), 4'b0, 2'd0);
    ped_req = 4'b0100;
    expect_n("s7_g0", 1, P_G, one(0, C_G), 4'b0, 2'd0);
    ped_req = 4'b0;
    expect_n("s7_g0", 3, P_G, one(0, C_G), 4'b0, 2'd0);
    expect_n("s7_y0", 1, P_Y, one(0, C_Y), 4'b0, 2'd0);
    rst = 1'b1;
    ena = 1'b0;
    expect_n("s7_reset_mid_yellow", 1, P_AR, ALLR, 4'b0, 2'd3);
    rst = 1'b0;
    ena = 1'b1;
    expect_n("s7_no_ped_after_reset", 1, P_G, one(0, C_G), 4'b0, 2'd0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
